// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// sequencer states and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shifting shift-add for multiply, or one
// restoring shift-subtract for divide, selected by is_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   acc_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           fits;

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift the {acc, q} pair right. Divide: shift in the next dividend bit and
  // subtract the divisor when it fits.
  always_comb begin
    sum     = acc_in + (q_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    if (is_div) begin
      acc_out = fits ? (shifted - {1'b0, operand}) : shifted;
      q_out   = {q_in[WIDTH-2:0], fits};
    end else begin
      acc_out = {1'b0, sum[WIDTH:1]};
      q_out   = {sum[0], q_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO and MF/MT access.
// Optional MULDIV_EARLY_TERM_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_dec;
  logic [WIDTH:0]   acc, step_acc;
  logic [WIDTH-1:0] q, step_q, opnd;
  logic             is_div, neg_lo, neg_hi, div_zero;
  logic             accept, is_arith, is_signed, rt_zero;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
`endif

  assign stall     = start & busy;
  assign accept    = start & ~busy & ~flush;
  assign is_arith  = ~op[2];
  assign is_signed = ~op[0];
  assign rt_zero   = (rt_val == {WIDTH{1'b0}});
  assign cnt_dec   = cnt - CNT_ONE;
  assign rs_mag    = (is_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (is_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .q_in    (q),
    .operand (opnd),
    .acc_out (step_acc),
    .q_out   (step_q)
  );

  // After an early stop the product still sits cnt positions high in {acc, q}.
`ifdef MULDIV_EARLY_TERM_EN
  assign prod_raw = {acc[WIDTH-1:0], q} >> cnt;
  assign rem_mask = ~({WIDTH{1'b1}} << cnt_dec);
`else
  assign prod_raw = {acc[WIDTH-1:0], q};
`endif
  assign prod_fix = neg_lo ? -prod_raw : prod_raw;

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_arith) begin
          state_next = (op[1] && rt_zero) ? FIX : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == CNT_ONE) begin
          state_next = FIX;
`ifdef MULDIV_EARLY_TERM_EN
        end else if (!is_div && ((step_q & rem_mask) == {WIDTH{1'b0}})) begin
          state_next = FIX;
`endif
        end else begin
          state_next = CALC;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end else begin
      state_next = state_next;
    end
  end

  // Datapath: operand capture, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= {CW{1'b0}};
      acc      <= {(WIDTH+1){1'b0}};
      q        <= {WIDTH{1'b0}};
      opnd     <= {WIDTH{1'b0}};
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                div_zero <= op[1] & rt_zero;
                acc      <= {(WIDTH+1){1'b0}};
                cnt      <= CNT_LOAD;
                neg_lo   <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                neg_hi   <= is_signed & rs_val[WIDTH-1];
                opnd     <= op[1] ? rt_mag : rs_mag;
                // Divide-by-zero keeps the raw dividend so HI can return it.
                q        <= op[1] ? (rt_zero ? rs_val : rs_mag) : rt_mag;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= step_acc;
          q   <= step_q;
          cnt <= cnt_dec;
        end
        FIX: begin
          if (!flush) begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= q;
              lo <= {WIDTH{1'b1}};
            end else begin
              lo <= neg_lo ? -q : q;
              hi <= neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // MFHI/MFLO read port, valid only when the unit is idle.
  always_comb begin
    result       = {WIDTH{1'b0}};
    result_valid = 1'b0;
    if (start && !busy && op == OP_MFHI) begin
      result       = hi;
      result_valid = 1'b1;
    end else if (start && !busy && op == OP_MFLO) begin
      result       = lo;
      result_valid = 1'b1;
    end else begin
      result       = {WIDTH{1'b0}};
      result_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; inputs change on the
// falling edge and outputs are sampled 1 time unit after it.
module tb_muldiv_sequencer;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MFHI  = 3'b100;
  localparam logic [2:0] MFLO  = 3'b101;
  localparam logic [2:0] MTHI  = 3'b110;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, result_valid;
  logic [31:0] result, hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy), .stall(stall),
    .result(result), .result_valid(result_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then count cycles with busy high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    #1;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; rs_val = 32'h0; rt_val = 32'h0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy, stall, result_valid} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, stall, result_valid});
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo, result} !== 96'h0) $display("FAIL reset_regs: got hi=%h lo=%h result=%h expected all 0", hi, lo, result);
    else pass_cnt++;
  endtask

  task automatic test_multu();
    int c, exp_c;
`ifdef MULDIV_EARLY_TERM_EN
    exp_c = 3;
`else
    exp_c = 33;
`endif
    run_op(MULTU, 32'hFFFF_FFFF, 32'h2, c);
    total_cnt++;
    if (c !== exp_c) $display("FAIL multu_busy: got %0d expected %0d", c, exp_c);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int c;
    run_op(MULT, 32'hFFFF_FFFD, 32'h5, c);
    total_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffff1", hi, lo);
    else pass_cnt++;
    run_op(DIV, 32'hFFFF_FFF9, 32'h2, c);
    total_cnt++;
    if (c !== 33) $display("FAIL div_busy: got %0d expected 33", c);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
    else pass_cnt++;
    run_op(DIVU, 32'd100, 32'd7, c);
    total_cnt++;
    if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu: got hi=%h lo=%h expected hi=2 lo=e", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div_corner();
    int c;
    run_op(DIVU, 32'h7, 32'h0, c);
    total_cnt++;
    if (c !== 1) $display("FAIL div0_busy: got %0d expected 1", c);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) $display("FAIL div0_result: got hi=%h lo=%h expected hi=7 lo=ffffffff", hi, lo);
    else pass_cnt++;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, c);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf: got hi=%h lo=%h expected hi=0 lo=80000000", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_mf_stall();
    int n = 0;
    int bad = 0;
    @(negedge clk);
    start = 1'b1; op = MULT; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; op = MFLO;
    #1;
    while (busy && n < 100) begin
      if (stall !== 1'b1) bad++;
      n++;
      tick();
    end
    total_cnt++;
    if (bad !== 0 || n == 0) $display("FAIL mflo_stall: got %0d unstalled of %0d busy cycles expected 0 of >0", bad, n);
    else pass_cnt++;
    total_cnt++;
    if ({stall, result_valid, result} !== {1'b0, 1'b1, 32'd42}) $display("FAIL mflo_result: got stall=%b valid=%b result=%h expected 0 1 0000002a", stall, result_valid, result);
    else pass_cnt++;
    tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL mflo_nostate: got busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_flush_reset();
    int c;
    run_op(MTHI, 32'h0000_AAAA, 32'h0, c);
    @(negedge clk);
    start = 1'b1; op = MULT; rs_val = 32'd3; rt_val = 32'h4000_0000;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    total_cnt++;
    if ({busy, hi, lo} !== {1'b0, 32'h0000_AAAA, 32'd42}) $display("FAIL flush: got busy=%b hi=%h lo=%h expected 0 0000aaaa 0000002a", busy, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; op = MULT; rs_val = 32'd3; rt_val = 32'h4000_0000;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, hi, lo} !== 65'h0) $display("FAIL rst_midop: got busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_mthi_mfhi();
    int c, exp_c;
    run_op(MTHI, 32'h1234, 32'h0, c);
    @(negedge clk);
    start = 1'b1; op = MFHI;
    #1;
    total_cnt++;
    if ({result_valid, result} !== {1'b1, 32'h0000_1234}) $display("FAIL mfhi: got valid=%b result=%h expected 1 00001234", result_valid, result);
    else pass_cnt++;
    @(negedge clk); start = 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
    exp_c = 3;
`else
    exp_c = 33;
`endif
    run_op(MULTU, 32'd5, 32'd3, c);
    total_cnt++;
    if (c !== exp_c || lo !== 32'd15) $display("FAIL multu_small: got busy=%0d lo=%h expected %0d 0000000f", c, lo, exp_c);
    else pass_cnt++;
  endtask

  // A second op held from the first busy cycle is stalled through FIX and
  // accepted on the first idle cycle.
  task automatic test_back_to_back();
    int n = 0;
    int c = 0;
    @(negedge clk);
    start = 1'b1; op = MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk); rs_val = 32'd4; rt_val = 32'd5;
    #1;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    total_cnt++;
    if ({stall, lo} !== {1'b0, 32'd6}) $display("FAIL b2b_first: got stall=%b lo=%h expected 0 00000006", stall, lo);
    else pass_cnt++;
    @(negedge clk); start = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    else pass_cnt++;
    while (busy && c < 100) begin
      c++;
      tick();
    end
    total_cnt++;
    if (lo !== 32'd20) $display("FAIL b2b_second: got lo=%h expected 00000014", lo);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_corner();
    test_mf_stall();
    test_flush_reset();
    test_mthi_mfhi();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
